// File: rtl/debounce_arbiter.sv
// -----------------------------------------------------------------------------
// debounce_arbiter
//
// Multi-channel debouncer with one shared sample prescaler and a round-robin
// event port. Each raw input is synchronized with two flops, sampled once per
// prescaler tick, and its debounced level changes only after STABLE
// consecutive ticks that disagree with the current level. Every level change
// raises a per-channel pending flag. A round-robin arbiter turns pending flags
// into press/release events on one valid/ready port.
//
// Ports:
//   clock_i        sole clock, all logic on posedge
//   reset_i        synchronous active-high reset
//   in_i[N]        raw asynchronous inputs
//   level_o[N]     debounced levels
//   event_valid_o  event presented
//   event_ready_i  consumer accepts the presented event
//   event_id_o     channel of the presented event
//   event_level_o  new debounced level of that channel (1 press, 0 release)
//   overflow_o     sticky: a level change was folded into an unsent event
//   dbg_tick_o     prescaler sample tick (observability)
//   dbg_ptr_o      round-robin pointer (observability)
//
// Handshake: an event transfers on a rising clock edge where event_valid_o
// and event_ready_i are both high. While event_valid_o is high and
// event_ready_i is low, event_id_o and event_level_o hold. event_valid_o
// never depends combinationally on event_ready_i.
// -----------------------------------------------------------------------------
module debounce_arbiter #(
    parameter int N        = 4,
    parameter int TICK_DIV = 1000,
    parameter int STABLE   = 4,
    localparam int ID_W    = $clog2(N),
    localparam int CNT_W   = $clog2(STABLE + 1),
    localparam int PS_W    = $clog2(TICK_DIV)
) (
    input  logic            clock_i,
    input  logic            reset_i,
    input  logic [N-1:0]    in_i,
    output logic [N-1:0]    level_o,
    output logic            event_valid_o,
    input  logic            event_ready_i,
    output logic [ID_W-1:0] event_id_o,
    output logic            event_level_o,
    output logic            overflow_o,
    output logic            dbg_tick_o,
    output logic [ID_W-1:0] dbg_ptr_o
);

    // Prescaler
    logic [PS_W-1:0] presc_q, presc_d;
    logic            tick;

    // Synchronizer; only sync2_q (the synchronized sample) is used downstream
    logic [N-1:0] sync1_q, sync2_q;

    // Debounce state
    logic [N-1:0]            level_q, level_d;
    logic [N-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]            pending_q, pending_d;
    logic [N-1:0]            set_pend;
    logic [N-1:0]            clr_pend;

    // Arbiter / event port state
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic            valid_q, valid_d;
    logic [ID_W-1:0] id_q, id_d;
    logic            evlvl_q, evlvl_d;
    logic            overflow_q, overflow_d;

    logic            load;
    logic            grant_found;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W:0]   scan_idx;

    assign tick    = (presc_q == PS_W'(TICK_DIV - 1));
    assign presc_d = tick ? '0 : presc_q + 1'b1;

    // Per-channel debounce: the counter only advances on ticks that disagree
    // with the current level; any agreeing tick restarts the count.
    always_comb begin
        level_d  = level_q;
        cnt_d    = cnt_q;
        set_pend = '0;
        for (int i = 0; i < N; i++) begin
            if (tick) begin
                if (sync2_q[i] == level_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_W'(STABLE - 1)) begin
                    level_d[i]  = ~level_q[i];
                    cnt_d[i]    = '0;
                    set_pend[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Round-robin search: first pending channel at or above ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int j = 0; j < N; j++) begin
            scan_idx = {1'b0, ptr_q} + (ID_W + 1)'(j);
            if (scan_idx >= (ID_W + 1)'(N)) begin
                scan_idx = scan_idx - (ID_W + 1)'(N);
            end
            if (!grant_found && pending_q[scan_idx[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx[ID_W-1:0];
            end
        end
    end

    // Event port. A new event loads whenever the output slot is empty or is
    // being consumed this cycle. The event level is taken from level_d so a
    // toggle landing in the same cycle is reported with its new value.
    always_comb begin
        load       = (!valid_q || event_ready_i) && (|pending_q);
        valid_d    = valid_q;
        id_d       = id_q;
        evlvl_d    = evlvl_q;
        ptr_d      = ptr_q;
        clr_pend   = '0;
        if (load && grant_found) begin
            valid_d             = 1'b1;
            id_d                = grant_idx;
            evlvl_d             = level_d[grant_idx];
            clr_pend[grant_idx] = 1'b1;
            ptr_d               = (grant_idx == ID_W'(N - 1)) ? '0 : grant_idx + 1'b1;
        end else if (valid_q && event_ready_i) begin
            valid_d = 1'b0;
        end
        // A new set beats a same-cycle clear; it is only an overflow when the
        // earlier event for that channel is still unsent.
        pending_d  = (pending_q & ~clr_pend) | set_pend;
        overflow_d = overflow_q | (|(set_pend & pending_q & ~clr_pend));
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            presc_q    <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            level_q    <= '0;
            cnt_q      <= '0;
            pending_q  <= '0;
            ptr_q      <= '0;
            valid_q    <= 1'b0;
            id_q       <= '0;
            evlvl_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            sync1_q    <= in_i;
            sync2_q    <= sync1_q;
            level_q    <= level_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            ptr_q      <= ptr_d;
            valid_q    <= valid_d;
            id_q       <= id_d;
            evlvl_q    <= evlvl_d;
            overflow_q <= overflow_d;
        end
    end

    assign level_o       = level_q;
    assign event_valid_o = valid_q;
    assign event_id_o    = id_q;
    assign event_level_o = evlvl_q;
    assign overflow_o    = overflow_q;
    assign dbg_tick_o    = tick;
    assign dbg_ptr_o     = ptr_q;

endmodule

// File: doc/debounce_arbiter.md
# debounce_arbiter

Multi-channel debounce controller that owns the shared sample timebase for N raw button/switch inputs, filters each channel to a stable level, and arbitrates the resulting press/release events onto a single valid/ready event port. It sits between the board inputs and the downstream event consumer. It replaces per-button free-running edge triggers with one prescaler and one round-robin event stream.

## Interface
- N, default 4: number of input channels (2..16).
- TICK_DIV, default 1000: clock cycles per sample tick (≥2).
- STABLE, default 4: consecutive differing ticks required to accept a level change (≥1).
- clock  in  1  sole clock; all logic on posedge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- in  in  N  raw asynchronous inputs.
- level  out  N  debounced levels.
- event_valid  out  1  event presented.
- event_ready  in  1  consumer accepts event when high with event_valid.
- event_id  out  $clog2(N)  channel of presented event.
- event_level  out  1  new debounced level of that channel (1 = press, 0 = release).
- overflow  out  1  sticky: an event was lost.

## Operation
- Reset: prescaler=0, sync flops=0, level=0, per-channel counters=0, pending=0, rr pointer=0, event_valid=0, event_id=0, event_level=0, overflow=0. Reset wins over all other activity, including a mid-handshake event, which is discarded.
- Synchronizer: two flops per bit; only the synchronized value (s) is used.
- Prescaler: counts 0..TICK_DIV-1, wraps to 0. tick=1 in the cycle where count==TICK_DIV-1.
- Per channel i, on tick only:
  - s[i]==level[i]: cnt[i]=0.
  - s[i]!=level[i] and cnt[i]<STABLE-1: cnt[i]++.
  - s[i]!=level[i] and cnt[i]==STABLE-1: level[i] toggles, cnt[i]=0, pending[i] set.
  - If pending[i] is already 1 when it is set again: overflow=1 (sticky until reset), pending stays 1.
- Counter width: $clog2(STABLE+1). A bounce of fewer than STABLE differing ticks produces no change.
- Arbiter:
  - Load condition is (!event_valid || event_ready) and |pending.
  - Grant is the first pending channel searching from ptr upward, wrapping N-1→0.
  - On grant:
    - event_id=k.
    - event_level=level[k] (the current value, including a toggle written the same cycle).
    - event_valid=1.
    - pending[k] cleared.
    - ptr=(k+1) mod N.
  - If pending[k] sets and clears in the same cycle, set wins: pending stays 1 and no overflow.
  - Handshake with nothing pending: event_valid=0 next cycle.
- event_id and event_level hold stable while event_valid=1 and event_ready=0.

## Timing
- in→s: 2 cycles.
- Debounced change: level toggles on the clock edge closing the STABLE-th consecutive tick where s differs.
- Event: event_valid rises at the earliest on the next edge after pending sets (1 cycle after the level toggle).
- Back-to-back: with event_ready held high, one event per cycle. No bubble between events.
- Event latency is bounded by N−1 other grants after pending sets, given ready.
- Power-up with an input held high yields a press event after STABLE ticks.

## Test plan
Parameters N=4, TICK_DIV=4, STABLE=3.
- Reset then idle:
  - All outputs 0 for 100 cycles.
  - prescaler tick observed every 4th cycle.
- Clean press: in[2] 0→1 held, event_ready=1.
  - level[2]=1 after 3 ticks (≤14 cycles after sync).
  - Exactly one event with event_id=2, event_level=1.
  - Release yields event_id=2, event_level=0.
- Bounce: in[1] toggles with a 2-tick high pulse, then low.
  - No level change.
  - No event.
  - overflow=0.
- Simultaneous: in[0], in[1], in[3] rise together, event_ready=0 for 20 cycles, then 1.
  - event_id=0 holds while stalled.
  - Events follow in order 0,1,3, one per cycle after ready.
  - ptr then=0.
- Overflow: in[3] press, ready=0, then release completes while pending[3] still set behind a stalled event on channel 0.
  - overflow=1.
  - A single channel-3 event is delivered, with event_level=0.
- Reset mid-handshake: event_valid=1, ready=0, assert reset one cycle.
  - All outputs 0 next cycle.
  - No stale event afterwards.
